// File: rtl/seq_comparator.sv
// ============================================================================
//  Module   : seq_comparator
//  Brief    : Bit-serial MSB-first magnitude comparator, unsigned or signed
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic             b_gt,
  output logic             b_a_eq,
  output logic             a_gt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] C_IDX_MSB = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
  logic             b_gt_q;
  logic             b_a_eq_q;
  logic             a_gt_q;

  logic             b_bit_d;
  logic             a_bit_d;
  logic             b_wins_d;

  assign b_bit_d = b_q[idx_q];
  assign a_bit_d = a_q[idx_q];

  // A set sign bit means "smaller" in two's complement, so the sense flips there.
  assign b_wins_d = (sgn_q && (idx_q == C_IDX_MSB)) ? a_bit_d : b_bit_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      b_gt_q   <= 1'b0;
      b_a_eq_q <= 1'b0;
      a_gt_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            sgn_q    <= sgn;
            idx_q    <= C_IDX_MSB;
            b_gt_q   <= 1'b0;
            b_a_eq_q <= 1'b0;
            a_gt_q   <= 1'b0;
            state_q  <= CMP;
          end
        end
        CMP: begin
          if (b_bit_d != a_bit_d) begin
            b_gt_q   <= b_wins_d;
            a_gt_q   <= ~b_wins_d;
            b_a_eq_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (idx_q == '0) begin
            b_gt_q   <= 1'b0;
            a_gt_q   <= 1'b0;
            b_a_eq_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign b_gt   = b_gt_q;
  assign b_a_eq = b_a_eq_q;
  assign a_gt   = a_gt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_comparator.sv
// ============================================================================
//  Module   : tb_seq_comparator
//  Brief    : Directed self-checking bench for seq_comparator (WIDTH 8 and 2)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_comparator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sgn;
  logic [7:0] b;
  logic [7:0] a;
  logic       busy;
  logic       done;
  logic       b_gt;
  logic       b_a_eq;
  logic       a_gt;

  logic       start2;
  logic       sgn2;
  logic [1:0] b2;
  logic [1:0] a2;
  logic       busy2;
  logic       done2;
  logic       b_gt2;
  logic       b_a_eq2;
  logic       a_gt2;

  int n_checks = 0;
  int n_err    = 0;

  seq_comparator #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .b     (b),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .b_gt  (b_gt),
    .b_a_eq(b_a_eq),
    .a_gt  (a_gt)
  );

  seq_comparator #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .sgn   (sgn2),
    .b     (b2),
    .a     (a2),
    .busy  (busy2),
    .done  (done2),
    .b_gt  (b_gt2),
    .b_a_eq(b_a_eq2),
    .a_gt  (a_gt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation; reports done cycle, busy cycles and {b_gt,b_a_eq,a_gt} at done.
  task automatic run8(input logic s, input logic [7:0] bv, input logic [7:0] av,
                      output int cyc, output int busy_cnt, output logic [2:0] res);
    sgn   = s;
    b     = bv;
    a     = av;
    start = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
    if (busy) busy_cnt++;
    res = {b_gt, b_a_eq, a_gt};
    tick();
  endtask

  initial begin
    int         cyc;
    int         bcnt;
    logic [2:0] res;
    logic       saw_done;
    int         sweep_pass;
    int         sweep_total;

    rst    = 1'b1;
    start  = 1'b0;
    sgn    = 1'b0;
    b      = '0;
    a      = '0;
    start2 = 1'b0;
    sgn2   = 1'b0;
    b2     = '0;
    a2     = '0;

    #3;
    check("reset_outputs", 32'({busy, done, b_gt, b_a_eq, a_gt}), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Unsigned, MSB differs: done in cycle 2
    run8(1'b0, 8'hA5, 8'h5A, cyc, bcnt, res);
    check("a5_5a_done_cycle", 32'(cyc), 32'd2);
    check("a5_5a_busy_cycles", 32'(bcnt), 32'd2);
    check("a5_5a_result", 32'(res), 32'b100);
    check("a5_5a_idle_after", 32'({busy, done}), 32'h0);
    check("a5_5a_result_held", 32'({b_gt, b_a_eq, a_gt}), 32'b100);

    // Equal operands: full WIDTH cycles of CMP
    run8(1'b0, 8'h3C, 8'h3C, cyc, bcnt, res);
    check("eq_3c_done_cycle", 32'(cyc), 32'd9);
    check("eq_3c_busy_cycles", 32'(bcnt), 32'd9);
    check("eq_3c_result", 32'(res), 32'b010);

    // Signed: -128 < 127
    run8(1'b1, 8'h80, 8'h7F, cyc, bcnt, res);
    check("s_80_7f_done_cycle", 32'(cyc), 32'd2);
    check("s_80_7f_result", 32'(res), 32'b001);

    // Same operands unsigned: 128 > 127
    run8(1'b0, 8'h80, 8'h7F, cyc, bcnt, res);
    check("u_80_7f_result", 32'(res), 32'b100);

    // Signed: -2 < -1, differs only at bit 0
    run8(1'b1, 8'hFE, 8'hFF, cyc, bcnt, res);
    check("s_fe_ff_done_cycle", 32'(cyc), 32'd9);
    check("s_fe_ff_result", 32'(res), 32'b001);

    // Start while busy is ignored; operand change mid-operation has no effect
    sgn   = 1'b0;
    b     = 8'h01;
    a     = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    tick();
    cyc++;
    b     = 8'hFF;
    start = 1'b1;
    tick();
    cyc++;
    start = 1'b0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("busy_start_done_cycle", 32'(cyc), 32'd9);
    check("busy_start_result", 32'({b_gt, b_a_eq, a_gt}), 32'b100);
    tick();
    check("busy_start_busy_c10", 32'(busy), 32'd0);

    // start held through DONE: accepted in the next IDLE cycle
    sgn   = 1'b0;
    b     = 8'hF0;
    a     = 8'h0F;
    start = 1'b1;
    tick();
    b = 8'h00;
    a = 8'h80;
    tick();
    check("b2b_first_done", 32'({done, b_gt, b_a_eq, a_gt}), 32'b1100);
    tick();
    check("b2b_idle_gap", 32'({busy, done}), 32'h0);
    tick();
    check("b2b_second_busy", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    check("b2b_second_done", 32'({done, b_gt, b_a_eq, a_gt}), 32'b1001);
    tick();

    // Asynchronous reset in cycle 4 of an equal comparison
    sgn   = 1'b0;
    b     = 8'h11;
    a     = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({busy, done, b_gt, b_a_eq, a_gt}), 32'h0);
    tick();
    rst      = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    run8(1'b0, 8'h02, 8'h03, cyc, bcnt, res);
    check("post_reset_done_cycle", 32'(cyc), 32'd9);
    check("post_reset_result", 32'(res), 32'b001);

    // Exhaustive WIDTH=2 sweep against a reference model
    sweep_pass  = 0;
    sweep_total = 0;
    for (int sg = 0; sg < 2; sg++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ai = 0; ai < 4; ai++) begin
          logic [1:0] bv2;
          logic [1:0] av2;
          logic       gt;
          logic [2:0] exp_res;
          int         exp_cyc;
          bv2 = bi[1:0];
          av2 = ai[1:0];
          gt  = (sg != 0) ? ($signed(bv2) > $signed(av2)) : (bv2 > av2);
          exp_res = gt ? 3'b100 : ((bv2 == av2) ? 3'b010 : 3'b001);
          exp_cyc = (bv2[1] != av2[1]) ? 2 : 3;

          sgn2   = sg[0];
          b2     = bv2;
          a2     = av2;
          start2 = 1'b1;
          tick();
          start2 = 1'b0;
          cyc    = 1;
          while (!done2 && cyc < 10) begin
            tick();
            cyc++;
          end
          res = {b_gt2, b_a_eq2, a_gt2};
          check($sformatf("w2_result_s%0d_b%0d_a%0d", sg, bi, ai), 32'(res), 32'(exp_res));
          check($sformatf("w2_latency_s%0d_b%0d_a%0d", sg, bi, ai), 32'(cyc), 32'(exp_cyc));
          sweep_total++;
          if (res == exp_res && cyc == exp_cyc) sweep_pass++;
          tick();
        end
      end
    end
    $display("WIDTH=2 sweep: %0d of %0d vectors passed", sweep_pass, sweep_total);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, legal range 2..32, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, as its single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, as the request to begin a comparison; sampled only in IDLE.
REQ-005 The block SHALL have port sgn, input, 1 bit, as the mode select sampled with start: 0 = unsigned, 1 = two's-complement signed.
REQ-006 The block SHALL have port b, input, WIDTH bits, as operand b, sampled with start.
REQ-007 The block SHALL have port a, input, WIDTH bits, as operand a, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a comparison is in progress or completing.
REQ-009 The block SHALL have port done, output, 1 bit, as a one-cycle pulse marking valid results.
REQ-010 The block SHALL have port b_gt, output, 1 bit, as the registered result b > a.
REQ-011 The block SHALL have port b_a_eq, output, 1 bit, as the registered result b == a.
REQ-012 The block SHALL have port a_gt, output, 1 bit, as the registered result a > b.

Function
REQ-013 The FSM SHALL have states IDLE, CMP and DONE; busy SHALL be 1 exactly when the state is not IDLE.
REQ-014 IDLE with start=1 at an edge SHALL:
- latch a, b and sgn into internal registers;
- clear b_gt, b_a_eq and a_gt to 0;
- load bit index = WIDTH-1;
- go to CMP.
REQ-015 IDLE with start=0 SHALL hold all registers.
REQ-016 In CMP, each edge SHALL compare the latched bits b[idx] and a[idx], MSB first.
REQ-017 In CMP, if b[idx] != a[idx], the block SHALL set the result and go to DONE (early termination).
- Unsigned: b_gt = b[idx].
- Signed, idx = WIDTH-1: b_gt = a[idx], because the sign bit inverts the sense.
- Signed, idx < WIDTH-1: b_gt = b[idx].
- a_gt SHALL be the complement of b_gt, and b_a_eq SHALL be 0.
REQ-018 In CMP, if the bits are equal and idx = 0, the block SHALL set b_a_eq=1, b_gt=0 and a_gt=0, and go to DONE.
REQ-019 In CMP, if the bits are equal and idx > 0, the block SHALL decrement idx and stay in CMP.
REQ-020 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE on the next edge.
REQ-021 Latency SHALL be as follows:
- CMP lasts k cycles, where k = WIDTH - i and i is the index of the highest differing bit; k = WIDTH when a == b;
- done is high in cycle k+1 after the start edge.
REQ-022 Result outputs SHALL become valid in the same cycle as done and SHALL hold until the next accepted start.
REQ-023 Exactly one of b_gt, b_a_eq and a_gt SHALL be 1 whenever done=1.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 Changes on a, b or sgn after the start edge SHALL NOT affect the operation in progress.
REQ-026 start=1 in the DONE cycle SHALL be ignored; start held high SHALL be accepted in the following IDLE cycle, giving back-to-back operation.

Reset
REQ-027 Asserting rst SHALL immediately, without waiting for clk:
- force the state to IDLE;
- set busy, done, b_gt, b_a_eq and a_gt to 0;
- clear idx and all operand registers to 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8 unless stated)
REQ-030 The bench SHALL apply sgn=0, b=0xA5, a=0x5A, start pulse and require:
- done 2 cycles after the start edge (k=1);
- b_gt=1, b_a_eq=0, a_gt=0.
REQ-031 The bench SHALL apply sgn=0, b=a=0x3C and require:
- busy high for 9 cycles;
- done in cycle 9;
- b_a_eq=1, b_gt=0, a_gt=0.
REQ-032 The bench SHALL apply sgn=1, b=0x80, a=0x7F and require:
- a_gt=1 with done in cycle 2;
- for sgn=1, b=0xFE, a=0xFF: a_gt=1 with done in cycle 9 (k=8).
REQ-033 The bench SHALL start with b=0x01, a=0x00, then change b to 0xFF and pulse start again at cycle 3, and require:
- the second start is ignored;
- done in cycle 9 with b_gt=1;
- busy returns to 0 in cycle 10.
REQ-034 The bench SHALL assert rst in cycle 4 of a b=a=0x11 comparison and require:
- busy=0 and all results 0 immediately;
- no done pulse;
- a following start with b=0x02, a=0x03 completes with a_gt=1.
REQ-035 The bench SHALL run an exhaustive check for WIDTH=2 over all 16 a/b pairs × both sgn values against a reference model, require zero mismatches, and report a PASSED/FAILED count.
